// File: rtl/instruction_word_writer_pkg.sv
// Shared definitions for the instruction-word encode path: format codes, FSM states
// and the bit positions of each field inside a 16-bit instruction word.
package instruction_word_writer_pkg;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int WORD_W         = 16;

    typedef enum logic [1:0] {
        FMT_I       = 2'b00,
        FMT_R       = 2'b01,
        FMT_D       = 2'b10,
        FMT_ILLEGAL = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCEPT = 2'b01,
        ST_WRITE  = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    // Field positions shared with the instruction-register decoder.
    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int FUNCT_HI = 11;
    localparam int FUNCT_LO = 8;
    localparam int REG_HI   = 7;
    localparam int REG_LO   = 5;
    localparam int REG2_HI  = 3;
    localparam int REG2_LO  = 1;
    localparam int DELTA_HI = 4;
    localparam int DELTA_LO = 1;
    localparam int LOC_BIT  = 0;
    localparam int IMM_HI   = 11;
    localparam int IMM_LO   = 0;

endpackage

// File: rtl/instruction_word_writer_packer.sv
// Combinational packer: assembles decoded fields into one 16-bit instruction word
// according to the format code, and flags the reserved format.
module instr_field_packer
    import instruction_word_writer_pkg::*;
(
    input  logic [1:0]  fmt_i,
    input  logic [3:0]  opcode_i,
    input  logic [3:0]  funct_i,
    input  logic [2:0]  reg_select_i,
    input  logic [2:0]  reg_select2_i,
    input  logic [3:0]  delta_i,
    input  logic        location_select_i,
    input  logic [11:0] imm_i,
    output logic [15:0] word_o,
    output logic        illegal_o
);

    // Field placement per format; bit 4 of an R word stays zero.
    always_comb begin
        word_o    = 16'h0000;
        illegal_o = 1'b0;
        case (fmt_i)
            FMT_I: begin
                word_o[OPC_HI:OPC_LO] = opcode_i;
                word_o[IMM_HI:IMM_LO] = imm_i;
            end
            FMT_R: begin
                word_o[OPC_HI:OPC_LO]     = opcode_i;
                word_o[FUNCT_HI:FUNCT_LO] = funct_i;
                word_o[REG_HI:REG_LO]     = reg_select_i;
                word_o[REG2_HI:REG2_LO]   = reg_select2_i;
                word_o[LOC_BIT]           = location_select_i;
            end
            FMT_D: begin
                word_o[OPC_HI:OPC_LO]     = opcode_i;
                word_o[FUNCT_HI:FUNCT_LO] = funct_i;
                word_o[REG_HI:REG_LO]     = reg_select_i;
                word_o[DELTA_HI:DELTA_LO] = delta_i;
                word_o[LOC_BIT]           = location_select_i;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instruction_word_writer.sv
// Burst writer: accepts field bundles over valid/ready, packs each into a word and
// writes it to sequential instruction-memory addresses over a write/ack handshake.
module instruction_word_writer
    import instruction_word_writer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] word_count_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [1:0]        fmt_i,
    input  logic [3:0]        opcode_i,
    input  logic [3:0]        funct_i,
    input  logic [2:0]        reg_select_i,
    input  logic [2:0]        reg_select2_i,
    input  logic [3:0]        delta_i,
    input  logic              location_select_i,
    input  logic [11:0]       imm_i,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_data_o,
    input  logic              mem_ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fmt_error_o,
    output logic [ADDR_W-1:0] written_o
);

    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] ZERO_A = '0;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0]   written_q, written_d;
    logic [15:0]         data_q, data_d;
    logic                fmt_err_q, fmt_err_d;
    logic                in_ready_q, mem_write_q, busy_q, done_q;
    logic [15:0]         packed_s;
    logic                illegal_s;

    instr_field_packer u_packer (
        .fmt_i             (fmt_i),
        .opcode_i          (opcode_i),
        .funct_i           (funct_i),
        .reg_select_i      (reg_select_i),
        .reg_select2_i     (reg_select2_i),
        .delta_i           (delta_i),
        .location_select_i (location_select_i),
        .imm_i             (imm_i),
        .word_o            (packed_s),
        .illegal_o         (illegal_s)
    );

    // Next-state and datapath updates for the burst FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        written_d   = written_q;
        data_d      = data_q;
        fmt_err_d   = fmt_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    written_d = ZERO_A;
                    fmt_err_d = 1'b0;
                    if (word_count_i != ZERO_A) begin
                        addr_d      = base_addr_i;
                        remaining_d = word_count_i;
                        state_d     = ST_ACCEPT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                if (in_valid_i) begin
                    // An illegal bundle is swallowed without touching address or count.
                    if (illegal_s) begin
                        fmt_err_d = 1'b1;
                    end else begin
                        data_d  = packed_s;
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_WRITE: begin
                if (mem_ack_i) begin
                    addr_d      = addr_q + ONE_A;
                    written_d   = written_q + ONE_A;
                    remaining_d = remaining_q - ONE_A;
                    if (remaining_q == ONE_A) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs derived from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= ZERO_A;
            remaining_q <= ZERO_A;
            written_q   <= ZERO_A;
            data_q      <= 16'h0000;
            fmt_err_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            written_q   <= written_d;
            data_q      <= data_d;
            fmt_err_q   <= fmt_err_d;
            in_ready_q  <= (state_d == ST_ACCEPT);
            mem_write_q <= (state_d == ST_WRITE);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fmt_error_o = fmt_err_q;
    assign written_o   = written_q;

endmodule
